proc_freq_decoder: RTL and testbench

//  Consumer of the 32-bit procFreqId status word. Splits off the static identity fields and

---
 rtl/proc_freq_decoder.sv | 144 ++++++++++++++
 tb/tb_proc_freq_decoder.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/proc_freq_decoder.sv
// proc_freq_decoder
//   Consumes the 32-bit procFreqId status word. The static identity fields are
//   registered every cycle. The 6-digit BCD frequency field (kHz) goes through a
//   sequential multiply-by-10 loop, one digit per cycle, and is then range-checked.
//   Each conversion result is announced by a one-cycle freqUpdate pulse.
//
// Ports
//   clock           in   1   processor clock
//   reset           in   1   synchronous, active-high
//   procFreqId      in   32  [31:8] BCD kHz (MSD in [31:28]), [6:4] processors,
//                            [3] bios active, [2:0] processor id
//   processorIdOut  out  3   registered procFreqId[2:0]
//   nrOfProcessors  out  3   registered procFreqId[6:4]
//   biosActive      out  1   registered procFreqId[3]
//   freqKhz         out  20  last valid binary frequency in kHz
//   freqValid       out  1   freqKhz is range-checked and BCD-clean
//   freqUpdate      out  1   one-cycle pulse when a conversion result is written
//   bcdError        out  1   last conversion saw a digit > 9
//   rangeError      out  1   last conversion fell outside [MinValidKhz, MaxValidKhz]
//
// State table
//   state   | meaning
//   IDLE    | wait for the BCD field to differ from the last captured field
//   CONVERT | accumulate one digit per cycle, MSD first (6 cycles)
//   CHECK   | classify the result, update outputs, pulse freqUpdate

module proc_freq_decoder #(
  parameter int unsigned MinValidKhz = 1000,
  parameter int unsigned MaxValidKhz = 500000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] procFreqId,
  output logic [2:0]  processorIdOut,
  output logic [2:0]  nrOfProcessors,
  output logic        biosActive,
  output logic [19:0] freqKhz,
  output logic        freqValid,
  output logic        freqUpdate,
  output logic        bcdError,
  output logic        rangeError
);

  localparam logic [19:0] MIN_KHZ = MinValidKhz[19:0];
  localparam logic [19:0] MAX_KHZ = MaxValidKhz[19:0];

  typedef enum logic [1:0] {IDLE, CONVERT, CHECK} state_t;

  state_t      state;
  logic [23:0] field;
  logic [23:0] last_field;
  logic [23:0] shadow;
  logic [19:0] acc;
  logic [19:0] acc_mac;
  logic [2:0]  digit_idx;
  logic        err_flag;
  logic [4:0]  digit_lsb;
  logic [3:0]  digit;
  logic        range_err;

  assign field = procFreqId[31:8];

  always_comb begin
    digit_lsb = {digit_idx, 2'b00};
    digit     = shadow[digit_lsb +: 4];
    // acc*10 as shift-add; wraps silently on BCD errors, which discard acc anyway
    acc_mac   = (acc << 3) + (acc << 1) + {16'd0, digit};
    range_err = !err_flag && ((acc < MIN_KHZ) || (acc > MAX_KHZ));
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      processorIdOut <= '0;
      nrOfProcessors <= '0;
      biosActive     <= 1'b0;
    end else begin
      processorIdOut <= procFreqId[2:0];
      nrOfProcessors <= procFreqId[6:4];
      biosActive     <= procFreqId[3];
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= IDLE;
      last_field <= '0;
      shadow     <= '0;
      acc        <= '0;
      digit_idx  <= '0;
      err_flag   <= 1'b0;
      freqKhz    <= '0;
      freqValid  <= 1'b0;
      freqUpdate <= 1'b0;
      bcdError   <= 1'b0;
      rangeError <= 1'b0;
    end else begin
      freqUpdate <= 1'b0;
      case (state)
        IDLE: begin
          if (field != last_field) begin
            shadow     <= field;
            last_field <= field;
            acc        <= '0;
            digit_idx  <= 3'd5;
            err_flag   <= 1'b0;
            state      <= CONVERT;
          end
        end
        CONVERT: begin
          // A new word mid-conversion restarts from the MSD; the old one never reports.
          if (field != shadow) begin
            shadow     <= field;
            last_field <= field;
            acc        <= '0;
            digit_idx  <= 3'd5;
            err_flag   <= 1'b0;
          end else begin
            acc      <= acc_mac;
            err_flag <= err_flag | (digit > 4'd9);
            if (digit_idx == 3'd0) begin
              state <= CHECK;
            end else begin
              digit_idx <= digit_idx - 3'd1;
            end
          end
        end
        CHECK: begin
          bcdError   <= err_flag;
          rangeError <= range_err;
          if (!err_flag && !range_err) begin
            freqKhz   <= acc;
            freqValid <= 1'b1;
          end else begin
            freqValid <= 1'b0;
          end
          freqUpdate <= 1'b1;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_proc_freq_decoder.sv
module tb_proc_freq_decoder;

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] procFreqId;
  logic [2:0]  processorIdOut;
  logic [2:0]  nrOfProcessors;
  logic        biosActive;
  logic [19:0] freqKhz;
  logic        freqValid;
  logic        freqUpdate;
  logic        bcdError;
  logic        rangeError;

  proc_freq_decoder dut (
    .clock          (clock),
    .reset          (reset),
    .procFreqId     (procFreqId),
    .processorIdOut (processorIdOut),
    .nrOfProcessors (nrOfProcessors),
    .biosActive     (biosActive),
    .freqKhz        (freqKhz),
    .freqValid      (freqValid),
    .freqUpdate     (freqUpdate),
    .bcdError       (bcdError),
    .rangeError     (rangeError)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [31:0] word;
    int          pulses;
    logic [19:0] khz;
    logic        valid;
    logic        bcd;
    logic        rng;
  } vec_t;

  vec_t tbl[12];
  int   vectors = 0;
  int   miscompares = 0;
  logic prev_upd = 1'b0;

  // reference model state for the randomized phase
  logic [23:0] m_last;
  logic [19:0] m_khz;
  logic        m_valid, m_bcd, m_rng;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_res(input logic [19:0] khz, input logic valid, input logic bcd,
                           input logic rng);
    check("freqKhz", 32'(freqKhz), 32'(khz));
    check("freqValid", 32'(freqValid), 32'(valid));
    check("bcdError", 32'(bcdError), 32'(bcd));
    check("rangeError", 32'(rangeError), 32'(rng));
  endtask

  task automatic check_all_zero();
    check("rst_pid", 32'(processorIdOut), 32'd0);
    check("rst_nproc", 32'(nrOfProcessors), 32'd0);
    check("rst_bios", 32'(biosActive), 32'd0);
    check("rst_update", 32'(freqUpdate), 32'd0);
    check_res(20'd0, 1'b0, 1'b0, 1'b0);
  endtask

  // Step n edges, sample 1 time unit after each, count update pulses.
  task automatic observe(input logic [31:0] w, input int n, output int pulses, output int first);
    pulses = 0;
    first  = -1;
    for (int e = 1; e <= n; e++) begin
      @(posedge clock);
      #1;
      if (freqUpdate) begin
        pulses++;
        if (first < 0) first = e;
        check("update_back_to_back", 32'(prev_upd), 32'd0);
      end
      if (e == 1) begin
        check("processorIdOut", 32'(processorIdOut), 32'(w[2:0]));
        check("nrOfProcessors", 32'(nrOfProcessors), 32'(w[6:4]));
        check("biosActive", 32'(biosActive), 32'(w[3]));
      end
      prev_upd = freqUpdate;
    end
  endtask

  task automatic step_reset(input int n);
    reset = 1'b1;
    for (int e = 0; e < n; e++) begin
      @(posedge clock);
      #1;
      prev_upd = freqUpdate;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    int p, f, hold, v;
    logic        be, chg;
    logic [31:0] w;
    logic [3:0]  nib;

    tbl[0]  = '{32'h05000019, 1, 20'd50000,  1'b1, 1'b0, 1'b0};
    tbl[1]  = '{32'h0A000019, 1, 20'd50000,  1'b0, 1'b1, 1'b0};
    tbl[2]  = '{32'h00050019, 1, 20'd50000,  1'b0, 1'b0, 1'b1};
    tbl[3]  = '{32'h00100019, 1, 20'd1000,   1'b1, 1'b0, 1'b0};
    tbl[4]  = '{32'h00100035, 0, 20'd1000,   1'b1, 1'b0, 1'b0};
    tbl[5]  = '{32'h50000042, 1, 20'd500000, 1'b1, 1'b0, 1'b0};
    tbl[6]  = '{32'h50000142, 1, 20'd500000, 1'b0, 1'b0, 1'b1};
    tbl[7]  = '{32'h00099901, 1, 20'd500000, 1'b0, 1'b0, 1'b1};
    tbl[8]  = '{32'h00000001, 1, 20'd500000, 1'b0, 1'b0, 1'b1};
    tbl[9]  = '{32'h00123470, 1, 20'd1234,   1'b1, 1'b0, 1'b0};
    tbl[10] = '{32'h99999919, 1, 20'd1234,   1'b0, 1'b0, 1'b1};
    tbl[11] = '{32'h1F000019, 1, 20'd1234,   1'b0, 1'b1, 1'b0};

    // reset with the first word already present
    procFreqId = tbl[0].word;
    step_reset(3);
    check_all_zero();
    reset = 1'b0;

    for (int i = 0; i < 12; i++) begin
      procFreqId = tbl[i].word;
      observe(tbl[i].word, 12, p, f);
      check("pulse_count", 32'(p), 32'(tbl[i].pulses));
      if (tbl[i].pulses == 1) check("pulse_edge", 32'(f), 32'd8);
      check_res(tbl[i].khz, tbl[i].valid, tbl[i].bcd, tbl[i].rng);
    end

    // randomized phase against the arithmetic model
    m_last  = tbl[11].word[31:8];
    m_khz   = tbl[11].khz;
    m_valid = tbl[11].valid;
    m_bcd   = tbl[11].bcd;
    m_rng   = tbl[11].rng;
    for (int it = 0; it < 40; it++) begin
      if ($urandom_range(0, 4) == 0) begin
        w[31:8] = m_last;
      end else begin
        for (int k = 0; k < 6; k++) begin
          if ($urandom_range(0, 7) == 0) w[8+4*k +: 4] = 4'($urandom_range(10, 15));
          else                           w[8+4*k +: 4] = 4'($urandom_range(0, 9));
        end
      end
      w[7]   = 1'b0;
      w[6:0] = 7'($urandom_range(0, 127));
      v  = 0;
      be = 1'b0;
      for (int k = 5; k >= 0; k--) begin
        nib = w[8+4*k +: 4];
        if (nib > 4'd9) be = 1'b1;
        v = v * 10 + int'(nib);
      end
      chg  = (w[31:8] != m_last);
      hold = $urandom_range(9, 14);
      procFreqId = w;
      observe(w, hold, p, f);
      if (chg) begin
        m_last = w[31:8];
        m_bcd  = be;
        m_rng  = !be && (v < 1000 || v > 500000);
        if (!be && !m_rng) begin
          m_khz   = 20'(v);
          m_valid = 1'b1;
        end else begin
          m_valid = 1'b0;
        end
      end
      check("rand_pulse_count", 32'(p), chg ? 32'd1 : 32'd0);
      if (chg) check("rand_pulse_edge", 32'(f), 32'd8);
      check_res(m_khz, m_valid, m_bcd, m_rng);
    end

    // reset during CONVERT, word held across release
    procFreqId = 32'h00000019;
    step_reset(2);
    reset = 1'b0;
    procFreqId = 32'h02500019;
    observe(procFreqId, 3, p, f);
    check("pre_reset_pulses", 32'(p), 32'd0);
    step_reset(2);
    check_all_zero();
    reset = 1'b0;
    observe(procFreqId, 12, p, f);
    check("post_reset_pulses", 32'(p), 32'd1);
    check("post_reset_edge", 32'(f), 32'd8);
    check_res(20'd25000, 1'b1, 1'b0, 1'b0);

    // restart: new word three cycles into CONVERT
    procFreqId = 32'h05000019;
    observe(procFreqId, 4, p, f);
    check("aborted_pulses", 32'(p), 32'd0);
    procFreqId = 32'h07500019;
    observe(procFreqId, 14, p, f);
    check("restart_pulses", 32'(p), 32'd1);
    check("restart_edge", 32'(f), 32'd8);
    check_res(20'd75000, 1'b1, 1'b0, 1'b0);

    // long hold of an out-of-range word
    procFreqId = 32'h99999919;
    observe(procFreqId, 1000, p, f);
    check("hold_pulses", 32'(p), 32'd1);
    check("hold_edge", 32'(f), 32'd8);
    check_res(20'd75000, 1'b0, 1'b0, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
